tx_lane_packer: RTL and testbench

//  Tx-side counterpart of the Rx byte-valid generator. Takes a byte stream (8 bytes/beat)

---
 rtl/tx_lane_packer.sv | 218 +++++++++++++++++++++
 tb/tb_tx_lane_packer.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_lane_packer.sv
`default_nettype none
// ============================================================================
// Module      : tx_lane_packer
// Description : Repacks an 8-byte/beat Tx byte stream into PIPE-wide beats of
//               W = (PIPEWIDTH/8)*lanes bytes, with byte-valid mask, final-beat
//               padding and link-down flush. Optional counters are enabled by
//               defining TX_PACKER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_lane_packer #(
    parameter int         GEN1_PIPEWIDTH = 8,
    parameter int         GEN2_PIPEWIDTH = 16,
    parameter int         GEN3_PIPEWIDTH = 32,
    parameter int         GEN4_PIPEWIDTH = 8,
    parameter int         GEN5_PIPEWIDTH = 8,
    parameter logic [7:0] PAD_BYTE       = 8'hF7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [2:0]   gen,
    input  logic [4:0]   numberOfDetectedLanes,
    input  logic         linkup,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_data,
    input  logic [3:0]   in_bytes,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] out_data,
    output logic [63:0]  out_byte_valid,
    output logic         out_last
`ifdef TX_PACKER_STATS_EN
    ,
    output logic [31:0]  stat_beats,
    output logic [31:0]  stat_pad_bytes
`endif
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FILL  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    localparam logic [6:0] c_BPL1 = 7'(GEN1_PIPEWIDTH / 8);
    localparam logic [6:0] c_BPL2 = 7'(GEN2_PIPEWIDTH / 8);
    localparam logic [6:0] c_BPL3 = 7'(GEN3_PIPEWIDTH / 8);
    localparam logic [6:0] c_BPL4 = 7'(GEN4_PIPEWIDTH / 8);
    localparam logic [6:0] c_BPL5 = 7'(GEN5_PIPEWIDTH / 8);

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic [6:0]   r_count;
    logic [6:0]   r_cfg_w;
    logic [575:0] r_acc;

    logic [6:0]   w_bpl;
    logic [2:0]   w_lane_shift;
    logic [6:0]   w_dec_w;
    logic [6:0]   w_cur_w;
    logic         w_in_bytes_ok;
    logic         w_accept;
    logic         w_out_free;
    logic         w_emit_full;
    logic         w_emit_part;
    logic [6:0]   w_emit_n;
    logic [6:0]   w_base;
    logic [6:0]   w_count_nxt;
    logic [575:0] w_acc_nxt;
    logic [63:0]  w_wmask;
    logic [63:0]  w_cmask;
    logic [7:0]   w_in_mask;
    logic [511:0] w_wmask_bits;
    logic [511:0] w_cmask_bits;
    logic [63:0]  w_in_mask_bits;
    logic [63:0]  w_in_masked;
    logic [511:0] w_pad_bits;
    logic [511:0] w_out_data_nxt;
    logic [63:0]  w_out_bv_nxt;
    logic         w_out_last_nxt;

    // Lane counts are powers of two, so W is the per-lane byte width shifted.
    always_comb begin
        w_bpl        = 7'd0;
        w_lane_shift = 3'd4;
        case (gen)
            3'd1:    w_bpl = c_BPL1;
            3'd2:    w_bpl = c_BPL2;
            3'd3:    w_bpl = c_BPL3;
            3'd4:    w_bpl = c_BPL4;
            3'd5:    w_bpl = c_BPL5;
            default: w_bpl = 7'd0;
        endcase
        case (numberOfDetectedLanes)
            5'b00001: w_lane_shift = 3'd0;
            5'b00010: w_lane_shift = 3'd1;
            5'b00100: w_lane_shift = 3'd2;
            5'b01000: w_lane_shift = 3'd3;
            default:  w_lane_shift = 3'd4;
        endcase
        w_dec_w = w_bpl << w_lane_shift;
    end

    // Live config only matters in IDLE; a packet in flight uses the latched W.
    assign w_cur_w       = (r_state == c_IDLE) ? w_dec_w : r_cfg_w;
    assign in_ready      = !reset && linkup && (w_cur_w != 7'd0) &&
                           (r_state != c_DRAIN) && (r_count <= 7'd64);
    assign w_in_bytes_ok = (in_bytes != 4'd0) && (in_bytes <= 4'd8);
    assign w_accept      = in_valid && in_ready && w_in_bytes_ok;

    assign w_out_free  = !out_valid || out_ready;
    assign w_emit_full = w_out_free && (r_state != c_IDLE) && (r_cfg_w != 7'd0) &&
                         (r_count >= r_cfg_w);
    assign w_emit_part = w_out_free && (r_state == c_DRAIN) && (r_count != 7'd0) &&
                         (r_count < r_cfg_w);
    assign w_emit_n    = w_emit_full ? r_cfg_w : (w_emit_part ? r_count : 7'd0);

    assign w_wmask   = ~({64{1'b1}} << r_cfg_w);
    assign w_cmask   = ~({64{1'b1}} << r_count);
    assign w_in_mask = ~(8'hFF << in_bytes);

    for (genvar i = 0; i < 64; i++) begin : g_byte_mask
        assign w_wmask_bits[i*8 +: 8] = {8{w_wmask[i]}};
        assign w_cmask_bits[i*8 +: 8] = {8{w_cmask[i]}};
    end

    for (genvar i = 0; i < 8; i++) begin : g_in_mask
        assign w_in_mask_bits[i*8 +: 8] = {8{w_in_mask[i]}};
    end

    // Bytes above r_count are kept zero so appends can simply be OR-ed in.
    assign w_in_masked = in_data & w_in_mask_bits;
    assign w_base      = r_count - w_emit_n;
    assign w_count_nxt = w_base + (w_accept ? {3'b000, in_bytes} : 7'd0);
    assign w_acc_nxt   = (r_acc >> {w_emit_n, 3'b000}) |
                         (w_accept ? ({512'b0, w_in_masked} << {w_base, 3'b000}) : 576'b0);

    assign w_pad_bits     = {64{PAD_BYTE}};
    assign w_out_data_nxt = w_emit_part ?
                            ((r_acc[511:0] & w_cmask_bits) |
                             (w_pad_bits & w_wmask_bits & ~w_cmask_bits)) :
                            (r_acc[511:0] & w_wmask_bits);
    assign w_out_bv_nxt   = w_emit_part ? (w_cmask & w_wmask) : w_wmask;
    assign w_out_last_nxt = w_emit_part || ((r_state == c_DRAIN) && (r_count == r_cfg_w));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_accept) w_state_nxt = in_last ? c_DRAIN : c_FILL;
            c_FILL:  if (w_accept && in_last) w_state_nxt = c_DRAIN;
            c_DRAIN: if (out_valid && out_ready && out_last) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || !linkup) begin
            r_state <= c_IDLE;
            r_count <= 7'd0;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_acc   <= w_acc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cfg_w <= 7'd0;
        end else if ((r_state == c_IDLE) && w_accept) begin
            r_cfg_w <= w_dec_w;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_byte_valid <= '0;
            out_last       <= 1'b0;
        end else if (!linkup) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (w_emit_full || w_emit_part) begin
            out_valid      <= 1'b1;
            out_data       <= w_out_data_nxt;
            out_byte_valid <= w_out_bv_nxt;
            out_last       <= w_out_last_nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef TX_PACKER_STATS_EN
    logic [6:0]  w_pad_n;
    logic [32:0] w_pad_sum;

    assign w_pad_n   = r_cfg_w - r_count;
    assign w_pad_sum = {1'b0, stat_pad_bytes} + {26'd0, w_pad_n};

    // Counters survive link-down; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_beats     <= 32'd0;
            stat_pad_bytes <= 32'd0;
        end else begin
            if (out_valid && out_ready && (stat_beats != 32'hFFFF_FFFF)) begin
                stat_beats <= stat_beats + 32'd1;
            end
            if (linkup && w_emit_part) begin
                stat_pad_bytes <= w_pad_sum[32] ? 32'hFFFF_FFFF : w_pad_sum[31:0];
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tx_lane_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_lane_packer
// Description : Scoreboard bench for tx_lane_packer with a packet-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_lane_packer;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   gen;
    logic [4:0]   numberOfDetectedLanes;
    logic         linkup;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_data;
    logic [3:0]   in_bytes;
    logic         in_last;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [511:0] out_data;
    logic [63:0]  out_byte_valid;
    logic         out_last;
`ifdef TX_PACKER_STATS_EN
    logic [31:0]  stat_beats;
    logic [31:0]  stat_pad_bytes;
`endif

    always #5 clk = ~clk;

    tx_lane_packer dut (
        .clk                   (clk),
        .reset                 (reset),
        .gen                   (gen),
        .numberOfDetectedLanes (numberOfDetectedLanes),
        .linkup                (linkup),
        .in_valid              (in_valid),
        .in_ready              (in_ready),
        .in_data               (in_data),
        .in_bytes              (in_bytes),
        .in_last               (in_last),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .out_data              (out_data),
        .out_byte_valid        (out_byte_valid),
        .out_last              (out_last)
`ifdef TX_PACKER_STATS_EN
        ,
        .stat_beats            (stat_beats),
        .stat_pad_bytes        (stat_pad_bytes)
`endif
    );

    typedef struct {
        logic [511:0] data;
        logic [63:0]  bv;
        logic         last;
    } beat_t;

    beat_t        exp_q[$];
    int           tests_run    = 0;
    int           tests_failed = 0;
    int           handshakes   = 0;
    longint       pad_total    = 0;
    int           ready_mode   = 0;
    byte unsigned pkt[$];

    function automatic int cfg_w(input logic [2:0] g, input logic [4:0] l);
        int pw;
        int nl;
        case (g)
            3'd1: pw = 8;
            3'd2: pw = 16;
            3'd3: pw = 32;
            3'd4: pw = 8;
            3'd5: pw = 8;
            default: pw = 0;
        endcase
        case (l)
            5'b00001: nl = 1;
            5'b00010: nl = 2;
            5'b00100: nl = 4;
            5'b01000: nl = 8;
            default:  nl = 16;
        endcase
        return (pw / 8) * nl;
    endfunction

    function automatic logic [4:0] pick_lanes();
        case ($urandom_range(0, 5))
            0: return 5'b00001;
            1: return 5'b00010;
            2: return 5'b00100;
            3: return 5'b01000;
            4: return 5'b10000;
            default: return 5'b00011;
        endcase
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests_run++;
        tests_failed++;
        $display("FAIL %s: bound expired, required event did not occur", name);
    endtask

    // Packet-level model: chop into W-byte beats, pad the tail with F7.
    task automatic push_expected(input byte unsigned p[$], input int w);
        int len;
        len = p.size();
        for (int off = 0; off < len; off += w) begin
            beat_t b;
            b.data = '0;
            b.bv   = '0;
            for (int j = 0; j < w; j++) begin
                if (off + j < len) begin
                    b.data[j*8 +: 8] = p[off + j];
                    b.bv[j]          = 1'b1;
                end else begin
                    b.data[j*8 +: 8] = 8'hF7;
                    pad_total++;
                end
            end
            b.last = (off + w >= len);
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_accept(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!ok) fail_now("accept_timeout");
    endtask

    task automatic send_pkt(input byte unsigned p[$], input int beat_sz, input bit gaps, input int chg);
        int off;
        int n;
        bit ok;
        off = 0;
        push_expected(p, cfg_w(gen, numberOfDetectedLanes));
        while (off < p.size()) begin
            n = (beat_sz > 0) ? beat_sz : int'($urandom_range(1, 8));
            if (n > p.size() - off) n = p.size() - off;
            in_data = {$urandom(), $urandom()};
            for (int j = 0; j < n; j++) in_data[j*8 +: 8] = p[off + j];
            in_bytes = 4'(n);
            in_last  = (off + n == p.size());
            in_valid = 1'b1;
            wait_accept(ok);
            in_valid = 1'b0;
            if (!ok) return;
            if (off == 0 && chg == 1) numberOfDetectedLanes = 5'b00001;
            if (off == 0 && chg == 2) begin
                gen                   = 3'($urandom_range(1, 5));
                numberOfDetectedLanes = pick_lanes();
            end
            off += n;
            if (gaps) repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while ((exp_q.size() != 0 || out_valid) && c < 5000) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("drain_outstanding_beats", 512'(exp_q.size()), 512'd0);
    endtask

    function automatic void make_pkt(input int len);
        pkt.delete();
        for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
    endfunction

    // Backpressure generator
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: every output handshake pops and compares one expected beat.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                handshakes++;
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_beat: got data %h, expected no beat", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_byte_valid", 512'(out_byte_valid), 512'(e.bv));
                    check("out_last", 512'(out_last), 512'(e.last));
                end
            end
        end
    end

    initial begin
        bit ok;
`ifdef TX_PACKER_STATS_EN
        logic [31:0] s_beats;
        logic [31:0] s_pads;
`endif
        reset                 = 1'b1;
        linkup                = 1'b1;
        gen                   = 3'd1;
        numberOfDetectedLanes = 5'b00001;
        in_valid              = 1'b0;
        in_data               = '0;
        in_bytes              = 4'd0;
        in_last               = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 512'(in_ready), 512'd0);
        check("reset_out_valid", 512'(out_valid), 512'd0);
        check("reset_out_data", out_data, 512'd0);
        check("reset_out_byte_valid", 512'(out_byte_valid), 512'd0);
        check("reset_out_last", 512'(out_last), 512'd0);
`ifdef TX_PACKER_STATS_EN
        check("reset_stat_beats", 512'(stat_beats), 512'd0);
        check("reset_stat_pad_bytes", 512'(stat_pad_bytes), 512'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;

        // W=1, three bytes in one beat
        gen = 3'd1;
        numberOfDetectedLanes = 5'b00001;
        pkt = {8'hAA, 8'hBB, 8'hCC};
        send_pkt(pkt, 8, 1'b0, 0);
        wait_drain();

        // W=16, 20 bytes as 8,8,4
`ifdef TX_PACKER_STATS_EN
        s_beats = stat_beats;
        s_pads  = stat_pad_bytes;
`endif
        gen = 3'd3;
        numberOfDetectedLanes = 5'b00100;
        make_pkt(20);
        send_pkt(pkt, 8, 1'b0, 0);
        wait_drain();
`ifdef TX_PACKER_STATS_EN
        check("stat_beats_w16", 512'(stat_beats - s_beats), 512'd2);
        check("stat_pad_bytes_w16", 512'(stat_pad_bytes - s_pads), 512'd12);
`endif

        // W=64, exact-multiple packet: single beat, no pad beat
        gen = 3'd3;
        numberOfDetectedLanes = 5'b10000;
        make_pkt(64);
        send_pkt(pkt, 8, 1'b0, 0);
        wait_drain();

        // W=4 with a long downstream stall: accumulator must fill and stop accepting
        gen = 3'd2;
        numberOfDetectedLanes = 5'b00010;
        make_pkt(120);
        fork
            send_pkt(pkt, 8, 1'b0, 0);
            begin
                repeat (3) @(posedge clk);
                #2;
                ready_mode = 2;
                repeat (40) @(posedge clk);
                @(negedge clk);
                check("stall_in_ready_low", 512'(in_ready), 512'd0);
                #2;
                ready_mode = 0;
            end
        join
        wait_drain();

        // W=16, link drop after 10 bytes; the dropped data must never appear
        gen = 3'd2;
        numberOfDetectedLanes = 5'b01000;
        in_data  = {$urandom(), $urandom()};
        in_bytes = 4'd8;
        in_last  = 1'b0;
        in_valid = 1'b1;
        wait_accept(ok);
        in_bytes = 4'd2;
        wait_accept(ok);
        in_valid = 1'b0;
        linkup   = 1'b0;
        @(negedge clk);
        check("linkdown_in_ready", 512'(in_ready), 512'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("linkdown_out_valid", 512'(out_valid), 512'd0);
        check("linkdown_in_ready_held", 512'(in_ready), 512'd0);
        @(posedge clk);
        #1;
        linkup = 1'b1;
        make_pkt(37);
        send_pkt(pkt, 0, 1'b1, 0);
        wait_drain();

        // Invalid gen: never ready, never emits
        gen      = 3'd7;
        in_data  = {$urandom(), $urandom()};
        in_bytes = 4'd8;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("invalid_gen_in_ready", 512'(in_ready), 512'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("invalid_gen_out_valid", 512'(out_valid), 512'd0);
        @(posedge clk);
        #1;

        // Lane change x4 -> x1 mid-packet keeps W=16
        gen = 3'd3;
        numberOfDetectedLanes = 5'b00100;
        make_pkt(40);
        send_pkt(pkt, 8, 1'b0, 1);
        wait_drain();

        // Randomized packets, random config, backpressure and mid-packet config changes
        ready_mode = 1;
        for (int k = 0; k < 40; k++) begin
            gen = 3'($urandom_range(1, 5));
            numberOfDetectedLanes = pick_lanes();
            make_pkt(int'($urandom_range(1, 100)));
            send_pkt(pkt, 0, 1'b1, ($urandom_range(0, 3) == 0) ? 2 : 0);
        end
        wait_drain();
        #2;
        ready_mode = 0;

`ifdef TX_PACKER_STATS_EN
        check("stat_beats_total", 512'(stat_beats), 512'(handshakes));
        check("stat_pad_bytes_total", 512'(stat_pad_bytes), 512'(pad_total));
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
